// File: rtl/hog_bus_responder.sv
// hog_bus_responder
//   Fabric-side responder for the HPS external-bus bridge. Decodes bridge
//   accesses into an 8-word register bank that controls the HOG core, and
//   turns core completion pulses into a maskable, registered level interrupt.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   addr            byte address; word index = addr[ADDR_WIDTH-1:2]
//   bus_enable      access request, held by the bridge until it sees ack
//   r_wbar          1 = read, 0 = write
//   write_data      write data
//   byte_enable     write byte lanes
//   read_data       read word, valid while ack=1, 0 otherwise
//   ack             one-cycle acknowledge
//   irq             level interrupt (irq_en & pending, registered)
//   core_done       one-cycle completion pulse from the HOG core
//   core_busy       HOG core busy level
//   ctrl_start      one-cycle start pulse to the core
//   ctrl_clear      one-cycle soft-clear pulse to the core
//
// Register map (word index)
//   0 CTRL     [0] start W1P, [1] irq_en RW, [2] clear W1P
//   1 STATUS   [0] core_busy, [1] done_sticky
//   2 IRQ      [0] pending, write-1-to-clear
//   3 DONE_CNT count of core_done pulses
//   4 SCRATCH  RW
//   5 VERSION  RO
//   6,7        reserved, read 0
module hog_bus_responder #(
  parameter int                   ADDR_WIDTH = 5,
  parameter int                   BUS_WIDTH  = 32,
  parameter int                   BUS_BYTES  = BUS_WIDTH / 8,
  parameter logic [BUS_WIDTH-1:0] VERSION    = 32'h484F_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  bus_enable,
  input  logic                  r_wbar,
  input  logic [BUS_WIDTH-1:0]  write_data,
  input  logic [BUS_BYTES-1:0]  byte_enable,
  output logic [BUS_WIDTH-1:0]  read_data,
  output logic                  ack,
  output logic                  irq,
  input  logic                  core_done,
  input  logic                  core_busy,
  output logic                  ctrl_start,
  output logic                  ctrl_clear
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_IRQ      = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_DONE_CNT = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_SCRATCH  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_VERSION  = IDX_W'(5);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    TURN
  } state_t;

  state_t state, state_nx;

  logic                 irq_en;
  logic                 pending;
  logic                 done_sticky;
  logic [BUS_WIDTH-1:0] done_cnt;
  logic [BUS_WIDTH-1:0] scratch;
  logic [BUS_WIDTH-1:0] rd_word;

  logic [IDX_W-1:0] word_idx;
  logic             access;
  logic             wr_ctrl;
  logic             wr_irq;
  logic             wr_scratch;
  logic             pending_clr;

  // Byte offset within the word is ignored: word-aligned access only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus_enable) state_nx = ACK;
      ACK:     state_nx = TURN;
      TURN:    state_nx = IDLE;   // bus_enable still driven by bridge; ignored
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack = (state == ACK);
  end

  // ------------------------------------------------------------- decode
  // The access is performed on the same edge that first samples
  // bus_enable, so the bus inputs are consumed directly rather than through
  // a separate latch stage.
  assign word_idx    = addr[ADDR_WIDTH-1:2];
  assign access      = (state == IDLE) && bus_enable;
  assign wr_ctrl     = access && !r_wbar && (word_idx == IDX_CTRL) && byte_enable[0];
  assign wr_irq      = access && !r_wbar && (word_idx == IDX_IRQ) && byte_enable[0];
  assign wr_scratch  = access && !r_wbar && (word_idx == IDX_SCRATCH);
  assign pending_clr = wr_irq && write_data[0];

  always_comb begin
    rd_word = '0;
    case (word_idx)
      IDX_CTRL:     rd_word[1] = irq_en;
      IDX_STATUS: begin
        rd_word[0] = core_busy;
        rd_word[1] = done_sticky;
      end
      IDX_IRQ:      rd_word[0] = pending;
      IDX_DONE_CNT: rd_word = done_cnt;
      IDX_SCRATCH:  rd_word = scratch;
      IDX_VERSION:  rd_word = VERSION;
      default:      rd_word = '0;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data   <= '0;
      ctrl_start  <= 1'b0;
      ctrl_clear  <= 1'b0;
      irq_en      <= 1'b0;
      pending     <= 1'b0;
      done_sticky <= 1'b0;
      done_cnt    <= '0;
      scratch     <= '0;
      irq         <= 1'b0;
    end else begin
      // read_data is only non-zero during the ACK cycle.
      read_data  <= (access && r_wbar) ? rd_word : '0;
      ctrl_start <= wr_ctrl && write_data[0];
      ctrl_clear <= wr_ctrl && write_data[2];

      if (wr_ctrl) irq_en <= write_data[1];

      // A completion pulse always wins over a same-edge W1C.
      pending <= core_done || (pending && !pending_clr);

      // A completion coinciding with the clear pulse is kept, not dropped.
      if (ctrl_clear) begin
        done_sticky <= core_done;
        done_cnt    <= core_done ? BUS_WIDTH'(1) : '0;
      end else if (core_done) begin
        done_sticky <= 1'b1;
        done_cnt    <= done_cnt + BUS_WIDTH'(1);
      end

      for (int unsigned i = 0; i < BUS_BYTES; i++) begin
        if (wr_scratch && byte_enable[i]) scratch[8*i +: 8] <= write_data[8*i +: 8];
      end

      irq <= irq_en && pending;
    end
  end

endmodule

// File: tb/tb_hog_bus_responder.sv
module tb_hog_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic        bus_enable;
  logic        r_wbar;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        ack;
  logic        irq;
  logic        core_done;
  logic        core_busy;
  logic        ctrl_start;
  logic        ctrl_clear;

  int checks   = 0;
  int failures = 0;

  hog_bus_responder #(
    .ADDR_WIDTH (5),
    .BUS_WIDTH  (32),
    .BUS_BYTES  (4),
    .VERSION    (32'h484F_0001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .bus_enable  (bus_enable),
    .r_wbar      (r_wbar),
    .write_data  (write_data),
    .byte_enable (byte_enable),
    .read_data   (read_data),
    .ack         (ack),
    .irq         (irq),
    .core_done   (core_done),
    .core_busy   (core_busy),
    .ctrl_start  (ctrl_start),
    .ctrl_clear  (ctrl_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic        rw;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Fast bridge: drops bus_enable as soon as it sees ack.
  task automatic access(input logic [4:0] a, input logic rw, input logic [31:0] wd,
                        input logic [3:0] be, input logic done_at,
                        output logic [31:0] rd, output logic st, output logic cl);
    int lat;
    lat = 0;
    addr = a; r_wbar = rw; write_data = wd; byte_enable = be;
    core_done = done_at;
    bus_enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      core_done = 1'b0;
      if (ack) begin
        lat = n;
        break;
      end
    end
    bus_enable = 1'b0;
    rd = read_data; st = ctrl_start; cl = ctrl_clear;
    chk("ack_latency", 32'(lat), 32'd1);
    step();
    chk("ack_width", {31'd0, ack}, 32'd0);
    step();
  endtask

  task automatic done_pulse();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        st, cl;
    int          acks;

    vecs[0]  = '{5'h14, 1'b1, 32'h0000_0000, 4'h0, 32'h484F_0001};
    vecs[1]  = '{5'h10, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[2]  = '{5'h10, 1'b0, 32'h0000_5500, 4'h2, 32'h0000_0000};
    vecs[3]  = '{5'h10, 1'b1, 32'h0000_0000, 4'h0, 32'hDEAD_55EF};
    vecs[4]  = '{5'h13, 1'b1, 32'h0000_0000, 4'h0, 32'hDEAD_55EF};
    vecs[5]  = '{5'h10, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000};
    vecs[6]  = '{5'h10, 1'b1, 32'h0000_0000, 4'h0, 32'hDEAD_55EF};
    vecs[7]  = '{5'h1C, 1'b0, 32'h1234_5678, 4'hF, 32'h0000_0000};
    vecs[8]  = '{5'h1C, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[9]  = '{5'h18, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[10] = '{5'h00, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[11] = '{5'h04, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[12] = '{5'h0C, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[13] = '{5'h08, 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[14] = '{5'h10, 1'b0, 32'hAABB_CCDD, 4'h9, 32'h0000_0000};
    vecs[15] = '{5'h10, 1'b1, 32'h0000_0000, 4'h0, 32'hAAAD_55DD};

    rst = 1'b1; addr = '0; bus_enable = 1'b0; r_wbar = 1'b1;
    write_data = '0; byte_enable = '0; core_done = 1'b0; core_busy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_start", {31'd0, ctrl_start}, 32'd0);
    chk("rst_clear", {31'd0, ctrl_clear}, 32'd0);

    // Table-driven register accesses
    for (int i = 0; i < 16; i++) begin
      access(vecs[i].a, vecs[i].rw, vecs[i].wd, vecs[i].be, 1'b0, rd, st, cl);
      if (vecs[i].rw) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Live core_busy in STATUS
    core_busy = 1'b1;
    access(5'h04, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("status_busy", rd, 32'h1);
    core_busy = 1'b0;

    // CTRL = start | irq_en
    access(5'h00, 1'b0, 32'h3, 4'h1, 1'b0, rd, st, cl);
    chk("start_pulse_in_ack", {31'd0, st}, 32'd1);
    chk("start_pulse_gone", {31'd0, ctrl_start}, 32'd0);
    access(5'h00, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("ctrl_read", rd, 32'h2);

    // Two completions: irq follows pending one cycle late
    done_pulse();
    chk("irq_registered_lag", {31'd0, irq}, 32'd0);
    step();
    chk("irq_after_done", {31'd0, irq}, 32'd1);
    done_pulse();
    step();
    access(5'h0C, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("done_cnt_2", rd, 32'd2);
    access(5'h04, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("status_sticky", rd, 32'h2);
    access(5'h08, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("irq_pending_read", rd, 32'h1);

    // W1C racing a completion: set wins
    access(5'h08, 1'b0, 32'h1, 4'h1, 1'b1, rd, st, cl);
    chk("irq_w1c_race", {31'd0, irq}, 32'd1);
    access(5'h08, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("pending_w1c_race", rd, 32'h1);
    access(5'h0C, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("done_cnt_3", rd, 32'd3);

    // Plain W1C
    access(5'h08, 1'b0, 32'h1, 4'h1, 1'b0, rd, st, cl);
    chk("irq_w1c", {31'd0, irq}, 32'd0);
    access(5'h08, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("pending_w1c", rd, 32'h0);

    // Masked interrupt, then unmask
    access(5'h00, 1'b0, 32'h0, 4'h1, 1'b0, rd, st, cl);
    done_pulse();
    step();
    step();
    chk("irq_masked", {31'd0, irq}, 32'd0);
    access(5'h00, 1'b0, 32'h2, 4'h1, 1'b0, rd, st, cl);
    chk("irq_unmasked", {31'd0, irq}, 32'd1);

    // Soft clear
    access(5'h00, 1'b0, 32'h4, 4'h1, 1'b0, rd, st, cl);
    chk("clear_pulse_in_ack", {31'd0, cl}, 32'd1);
    chk("start_not_pulsed", {31'd0, st}, 32'd0);
    access(5'h0C, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("done_cnt_cleared", rd, 32'd0);
    access(5'h04, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("sticky_cleared", rd, 32'd0);

    // Slow bridge: bus_enable held through ACK and TURN
    addr = 5'h10; r_wbar = 1'b1; bus_enable = 1'b1;
    acks = 0;
    rd = '0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (ack) begin
        acks++;
        rd = read_data;
      end
      if (i == 3) bus_enable = 1'b0;
    end
    chk("slow_bridge_acks", 32'(acks), 32'd1);
    chk("slow_bridge_rdata", rd, 32'hAAAD_55DD);

    // Reset in the ACK cycle abandons the access
    addr = 5'h10; r_wbar = 1'b1; bus_enable = 1'b1;
    step();
    chk("pre_rst_ack", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    bus_enable = 1'b0;
    step();
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_rdata", read_data, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    step();
    access(5'h10, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("scratch_after_rst", rd, 32'd0);
    access(5'h08, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("pending_after_rst", rd, 32'd0);
    access(5'h00, 1'b1, '0, '0, 1'b0, rd, st, cl);
    chk("ctrl_after_rst", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
